mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1, synchronous active-low reset sampled on clk rising edge.
REQ-003 SHALL have port alu_out_mem, input, 32, ALU result from EX, used as data address or write-back value.
REQ-004 SHALL have port st_data_mem, input, 32, store data (Rs2 value).
REQ-005 SHALL have port d_write_enable_mem, input, 1, store request.
REQ-006 SHALL have port d_load_enable_mem, input, 1, load request.
REQ-007 SHALL have port rd_mem, input, 5, destination register index.
REQ-008 SHALL have port valid_mem, input, 1, instruction present in MEM.
REQ-009 SHALL have ports d_addr (output, 32), d_wdata (output, 32), d_req (output, 1), d_we (output, 1), d_rdata (input, 32) and d_ack (input, 1), forming the data-memory request/acknowledge interface.
REQ-010 SHALL have port stall_out, output, 1, which freezes IF/ID/EX registers while high.
REQ-011 SHALL have ports fwd_data (output, 32) and fwd_rd (output, 5), the forwarding path back to EX.
REQ-012 SHALL have ports wb_data (output, 32), wb_rd (output, 5) and wb_we (output, 1), registered outputs to WB.
REQ-013 SHALL have port bus_err, output, 1, a sticky error flag.

Function
REQ-014 SHALL define a memory op as valid_mem & (d_write_enable_mem | d_load_enable_mem); when both enables are set, the store takes priority.
REQ-015 SHALL drive d_addr=alu_out_mem, d_wdata=st_data_mem and d_we=store combinationally.
REQ-016 SHALL implement FSM states IDLE and WAIT.
  - IDLE + memory op + aligned address: d_req=1.
    - d_ack=1 in the same cycle: completes; stay IDLE.
    - otherwise: go to WAIT.
  - WAIT: d_req=1 held.
    - d_ack=1: complete; go to IDLE.
    - timeout: abort; go to IDLE.
REQ-017 SHALL keep a 4-bit wait counter.
  - Cleared in IDLE.
  - Increments each cycle d_req=1 && d_ack=0.
  - Timeout = WAIT && cnt==15 && !d_ack, i.e. the 16th unacknowledged request cycle.
REQ-018 SHALL treat alu_out_mem[1:0]!=0 on a memory op as misaligned: no d_req, op aborts the same cycle.
REQ-019 SHALL drive stall_out = memory op & !(d_ack | timeout | misaligned) combinationally; upstream holds inputs stable while stall_out=1.
REQ-020 SHALL set bus_err at the clock edge of a timeout or misaligned abort; bus_err clears only on reset.
REQ-021 SHALL, at a clock edge with valid_mem=1 and stall_out=0, register to WB (1-cycle latency):
  - load completed: wb_data=d_rdata, wb_rd=rd_mem, wb_we=(rd_mem!=0).
  - store completed: wb_we=0.
  - non-memory op: wb_data=alu_out_mem, wb_rd=rd_mem, wb_we=(rd_mem!=0).
  - aborted op: wb_we=0 and wb_data unchanged.
REQ-022 SHALL register wb_we=0 (bubble) at every edge where stall_out=1 or valid_mem=0; wb_data and wb_rd hold.
REQ-023 SHALL drive fwd_data=alu_out_mem and fwd_rd=rd_mem when valid_mem=1 and the op is not a load; otherwise fwd_rd=0, so a load address is never forwarded.
REQ-024 SHALL NOT drop or re-issue a request between d_req rising and d_ack or abort; d_addr, d_wdata and d_we remain stable during WAIT.
REQ-025 SHALL ignore d_ack when d_req=0.

Reset
REQ-026 SHALL, when reset_n=0 at a clock edge, set state=IDLE, cnt=0, wb_data=0, wb_rd=0, wb_we=0 and bus_err=0.
REQ-027 SHALL, on reset during WAIT, deassert d_req from the cycle after the reset edge; no completion is reported to WB.

Verification
REQ-028 SHALL verify: ALU op with alu_out=0x0000_0010, rd=5, valid=1 -> next edge wb_data=0x10, wb_rd=5, wb_we=1; fwd_rd=5 in the same cycle; stall_out=0.
REQ-029 SHALL verify: load at addr 0x100, rd=7, d_ack after 3 wait cycles with d_rdata=0xDEADBEEF -> stall_out=1 for 3 cycles, wb_we=0 during stall, then wb_data=0xDEADBEEF, wb_rd=7, wb_we=1; fwd_rd=0 throughout.
REQ-030 SHALL verify: store to 0x200 with data 0x1234, d_ack in the same cycle -> d_req=1 and d_we=1 for 1 cycle, no stall, wb_we=0.
REQ-031 SHALL verify: load with d_ack never asserted -> d_req high exactly 16 cycles, stall_out falls on the 16th, bus_err=1 after that edge, wb_we=0.
REQ-032 SHALL verify: load at 0x102 -> d_req never asserted, stall_out=0, bus_err=1 next edge.
REQ-033 SHALL verify: reset_n=0 at the 2nd WAIT cycle of a load -> state IDLE, d_req=0, wb_we=0, bus_err=0 after the reset edge.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory request FSM with wait timeout,
// misalignment abort, EX forwarding and registered write-back bundle.
module mem_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] alu_out_mem,
  input  logic [31:0] st_data_mem,
  input  logic        d_write_enable_mem,
  input  logic        d_load_enable_mem,
  input  logic [4:0]  rd_mem,
  input  logic        valid_mem,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic        d_req,
  output logic        d_we,
  input  logic [31:0] d_rdata,
  input  logic        d_ack,
  output logic        stall_out,
  output logic [31:0] fwd_data,
  output logic [4:0]  fwd_rd,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        bus_err
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_wb_we;
  logic        r_bus_err;

  logic w_mem_op;
  logic w_store;
  logic w_load;
  logic w_mis;
  logic w_ack;
  logic w_timeout;
  logic w_abort;

  // Store wins when both enables are set
  assign w_mem_op  = valid_mem & (d_write_enable_mem | d_load_enable_mem);
  assign w_store   = w_mem_op & d_write_enable_mem;
  assign w_load    = w_mem_op & ~d_write_enable_mem & d_load_enable_mem;
  assign w_mis     = w_mem_op & (|alu_out_mem[1:0]);

  assign d_req     = (r_state == S_WAIT)
                   | ((r_state == S_IDLE) & w_mem_op & ~w_mis);
  assign w_ack     = d_req & d_ack;
  assign w_timeout = (r_state == S_WAIT) & (r_cnt == 4'hF) & ~d_ack;
  assign w_abort   = w_timeout | w_mis;

  assign d_addr    = alu_out_mem;
  assign d_wdata   = st_data_mem;
  assign d_we      = w_store;
  assign stall_out = w_mem_op & ~(w_ack | w_timeout | w_mis);

  // A load's address must never look like a forwardable result
  assign fwd_data  = alu_out_mem;
  assign fwd_rd    = (valid_mem & ~w_load) ? rd_mem : 5'd0;

  assign wb_data   = r_wb_data;
  assign wb_rd     = r_wb_rd;
  assign wb_we     = r_wb_we;
  assign bus_err   = r_bus_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: if (d_req & ~d_ack)      r_state <= S_WAIT;
        S_WAIT: if (d_ack | w_timeout)   r_state <= S_IDLE;
        default:                         r_state <= S_IDLE;
      endcase
      r_cnt <= (d_req & ~d_ack & ~w_timeout) ? r_cnt + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wb_data <= 32'd0;
      r_wb_rd   <= 5'd0;
      r_wb_we   <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_abort) r_bus_err <= 1'b1;
      r_wb_we <= 1'b0;
      if (valid_mem & ~stall_out & ~w_abort) begin
        if (w_load) begin
          r_wb_data <= d_rdata;
          r_wb_rd   <= rd_mem;
          r_wb_we   <= |rd_mem;
        end else if (!w_store) begin
          r_wb_data <= alu_out_mem;
          r_wb_rd   <= rd_mem;
          r_wb_we   <= |rd_mem;
        end
      end
    end
  end

endmodule
